cordic_result_serializer: RTL and testbench
===========================================

CORDIC_RESULT_SERIALIZER -- requirements
Module: cordic_result_serializer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchroniser depth for out_ack (legal 2..3).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 ena  input  1  tile enable; low = freeze.
REQ-005 res_valid  input  1  CORDIC core result strobe.
REQ-006 res_cos  input  16  signed Q1.14 cosine result.
REQ-007 res_sin  input  16  signed Q1.14 sine result.
REQ-008 res_ready  output  1  result buffer can accept.
REQ-009 out_ack  input  1  asynchronous host acknowledge pin, rising edge = byte taken.
REQ-010 byte_out  output  8  current output byte.
REQ-011 byte_valid  output  1  byte_out holds a valid byte.
REQ-012 byte_idx  output  3  index of current byte within the frame.
REQ-013 busy  output  1  frame in progress or result buffered.

Function
REQ-014 Result accepted on a clock edge with res_valid && res_ready && ena high.
REQ-015 Storage: one active frame register plus one buffer register; res_ready = ena && !buffer_full.
REQ-016 Frame byte order: idx0 cos[7:0], idx1 cos[15:8], idx2 sin[7:0], idx3 sin[15:8].
REQ-017 FSM states IDLE, SEND; IDLE->SEND on acceptance; SEND->IDLE after last-byte ack with buffer empty.
REQ-018 Accept while IDLE: byte_valid=1, byte_idx=0, byte_out=cos[7:0] in the cycle after the accepting edge (latency 1).
REQ-019 Accept while SEND: result goes to the buffer; active frame unaffected.
REQ-020 out_ack passes through SYNC_STAGES flops, then rising-edge detect yields a 1-cycle ack_pulse.
REQ-021 ack_pulse in SEND advances byte_idx by 1; byte_out updates on the same edge.
REQ-022 ack_pulse on the last byte with buffer full: buffer moves to active on the same edge, byte_idx=0, byte_valid stays 1, buffer becomes empty.
REQ-023 Last-byte ack and a new acceptance on the same edge: new result lands in the buffer (buffer-full case) or directly in active (buffer-empty case), never lost.
REQ-024 ack_pulse in IDLE is ignored; out_ack held high produces one pulse only.
REQ-025 ena low: all state holds, ack_pulse ignored, res_ready=0; the synchroniser keeps running.
REQ-026 busy = (state==SEND) || buffer_full.

Reset
REQ-027 On rst_n low: state IDLE, buffer empty, byte_out=0x00, byte_valid=0, byte_idx=0, res_ready=0 while asserted, busy=0, synchroniser flops 0.
REQ-028 Reset mid-frame discards the active and buffered results; the first frame after release starts at idx0.

Configuration
REQ-029 Macro CORDIC_SER_CHECKSUM_EN defined: frame gains idx4 = XOR of bytes idx0..idx3; last byte is idx4.
REQ-030 Macro undefined: frame is 4 bytes; last byte is idx3; byte_idx never exceeds 3.

Structure
REQ-031 Shared package cordic_pkg holds the FSM state typedef, the frame-length constant (4/5 per macro), the byte-index constants and the result width 16.
REQ-032 Sub-module cordic_ack_sync (SYNC_STAGES synchroniser plus rising-edge detector) is instantiated once.

Verification
REQ-033 Reset, then cos=0x4DBA, sin=0x2D41, with 4 ack edges: bytes 0xBA, 0x4D, 0x41, 0x2D at idx 0..3, then IDLE, byte_valid=0.
REQ-034 Same vector with CORDIC_SER_CHECKSUM_EN: fifth byte 0x9B at idx4.
REQ-035 Two back-to-back results with no ack: second accepted, then res_ready=0 and a third res_valid is held off; after 4 acks the second frame starts at idx0 without a gap cycle.
REQ-036 out_ack held high for 10 cycles: exactly one advance, occurring SYNC_STAGES+1 edges after the first high sample.
REQ-037 rst_n pulsed low at idx2: outputs at reset values at once; the next result starts at idx0.
REQ-038 ena low during SEND plus an ack edge: idx unchanged and res_ready=0; after ena returns high, a new ack edge advances the index.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC result serializer.
// Frame length depends on CORDIC_SER_CHECKSUM_EN (5 bytes with checksum, 4 without).
package cordic_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  localparam int RES_W = 16;

`ifdef CORDIC_SER_CHECKSUM_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  localparam logic [2:0] IDX_COS_LO = 3'd0;
  localparam logic [2:0] IDX_COS_HI = 3'd1;
  localparam logic [2:0] IDX_SIN_LO = 3'd2;
  localparam logic [2:0] IDX_SIN_HI = 3'd3;
  localparam logic [2:0] IDX_CHK    = 3'd4;
  localparam logic [2:0] IDX_LAST   = 3'(FRAME_LEN - 1);

endpackage

// File: rtl/cordic_ack_sync.sv
// Synchroniser for the asynchronous host acknowledge pin plus a rising-edge
// detector producing a one-cycle pulse.
module cordic_ack_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/cordic_result_serializer.sv
// Serialises CORDIC cos/sin results into a byte frame handshaked by out_ack.
// Optional checksum byte at idx4 when CORDIC_SER_CHECKSUM_EN is defined.
module cordic_result_serializer
  import cordic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             res_valid,
  input  logic [RES_W-1:0] res_cos,
  input  logic [RES_W-1:0] res_sin,
  output logic             res_ready,
  input  logic             out_ack,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic [2:0]       byte_idx,
  output logic             busy
);

  ser_state_t         state_q, state_d;
  logic [2*RES_W-1:0] active_q, buffer_q, res_word;
  logic               buffer_full_q;
  logic [2:0]         idx_q;
  logic               run_q;
  logic               ack_pulse;
  logic               accept, ack, last, frame_done, reload, direct, to_buffer;
  logic [7:0]         sel_byte;

  cordic_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (out_ack),
    .pulse    (ack_pulse)
  );

  assign res_word   = {res_sin, res_cos};
  assign res_ready  = run_q && ena && !buffer_full_q;
  assign accept     = res_valid && res_ready;
  assign ack        = ena && ack_pulse && (state_q == SEND);
  assign last       = (idx_q == IDX_LAST);
  assign frame_done = ack && last;
  assign reload     = frame_done && buffer_full_q;
  assign direct     = frame_done && !buffer_full_q && accept;
  assign to_buffer  = accept && (state_q == SEND) && !direct;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = SEND;
      SEND: if (frame_done && !buffer_full_q && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // res_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q         <= 1'b0;
      active_q      <= '0;
      buffer_q      <= '0;
      buffer_full_q <= 1'b0;
      idx_q         <= 3'd0;
    end else begin
      run_q <= 1'b1;
      if (state_q == IDLE && accept) begin
        active_q <= res_word;
        idx_q    <= IDX_COS_LO;
      end else if (ack) begin
        if (!last) begin
          idx_q <= idx_q + 3'd1;
        end else begin
          idx_q <= IDX_COS_LO;
          if (reload)      active_q <= buffer_q;
          else if (direct) active_q <= res_word;
        end
      end
      if (to_buffer) begin
        buffer_q      <= res_word;
        buffer_full_q <= 1'b1;
      end else if (reload) begin
        buffer_full_q <= 1'b0;
      end
    end
  end

  always_comb begin
    sel_byte = 8'h00;
    case (idx_q)
      IDX_COS_LO: sel_byte = active_q[7:0];
      IDX_COS_HI: sel_byte = active_q[15:8];
      IDX_SIN_LO: sel_byte = active_q[23:16];
      IDX_SIN_HI: sel_byte = active_q[31:24];
`ifdef CORDIC_SER_CHECKSUM_EN
      IDX_CHK:    sel_byte = active_q[7:0] ^ active_q[15:8] ^ active_q[23:16] ^ active_q[31:24];
`endif
      default:    sel_byte = 8'h00;
    endcase
  end

  assign byte_valid = (state_q == SEND);
  assign byte_out   = byte_valid ? sel_byte : 8'h00;
  assign byte_idx   = idx_q;
  assign busy       = (state_q == SEND) || buffer_full_q;

endmodule

// File: tb/tb_cordic_result_serializer.sv
// Directed self-checking bench for cordic_result_serializer; expected bytes are
// hand-computed, checksum bytes used only when CORDIC_SER_CHECKSUM_EN is defined.
module tb_cordic_result_serializer;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        res_valid = 1'b0;
  logic [15:0] res_cos = '0;
  logic [15:0] res_sin = '0;
  logic        res_ready;
  logic        out_ack = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [2:0]  byte_idx;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  cordic_result_serializer #(.SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .res_valid  (res_valid),
    .res_cos    (res_cos),
    .res_sin    (res_sin),
    .res_ready  (res_ready),
    .out_ack    (out_ack),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_idx   (byte_idx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drive one result for a single cycle; inputs change on the falling edge.
  task automatic applyStimulus(input logic [15:0] c, input logic [15:0] s);
    res_valid = 1'b1;
    res_cos   = c;
    res_sin   = s;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic pulseAck();
    out_ack = 1'b1;
    cycles(SYNC + 2);
    out_ack = 1'b0;
    cycles(SYNC + 2);
  endtask

  task automatic expectByte(input string tag, input logic [2:0] idx, input logic [7:0] b);
    checkOutput({tag, " valid"}, 32'(byte_valid), 32'd1);
    checkOutput({tag, " idx"}, 32'(byte_idx), 32'(idx));
    checkOutput({tag, " byte"}, 32'(byte_out), 32'(b));
  endtask

  task automatic expectIdle(input string tag);
    checkOutput({tag, " valid"}, 32'(byte_valid), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  int gaps;

  initial begin
    // Reset values
    @(negedge clk);
    checkOutput("rst byte_out", 32'(byte_out), 32'h00);
    checkOutput("rst valid", 32'(byte_valid), 32'd0);
    checkOutput("rst idx", 32'(byte_idx), 32'd0);
    checkOutput("rst ready", 32'(res_ready), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cycles(2);
    checkOutput("ready after rst", 32'(res_ready), 32'd1);

    // Basic frame 0x4DBA / 0x2D41
    applyStimulus(16'h4DBA, 16'h2D41);
    expectByte("A0", 3'd0, 8'hBA);
    checkOutput("A0 busy", 32'(busy), 32'd1);
    pulseAck(); expectByte("A1", 3'd1, 8'h4D);
    pulseAck(); expectByte("A2", 3'd2, 8'h41);
    pulseAck(); expectByte("A3", 3'd3, 8'h2D);
`ifdef CORDIC_SER_CHECKSUM_EN
    pulseAck(); expectByte("A4", 3'd4, 8'h9B);
`endif
    pulseAck(); expectIdle("A end");

    // Held-high ack: single advance at the third edge after the first sample
    applyStimulus(16'h0102, 16'h0304);
    out_ack = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == SYNC)     checkOutput("hold before", 32'(byte_idx), 32'd0);
      if (i == SYNC + 1) checkOutput("hold advance", 32'(byte_idx), 32'd1);
      if (i == 10)       checkOutput("hold single", 32'(byte_idx), 32'd1);
    end
    out_ack = 1'b0;
    cycles(SYNC + 2);

    // ena low freezes state and blocks acks
    ena = 1'b0;
    @(negedge clk);
    checkOutput("ena0 ready", 32'(res_ready), 32'd0);
    pulseAck();
    checkOutput("ena0 idx", 32'(byte_idx), 32'd1);
    checkOutput("ena0 byte", 32'(byte_out), 32'h01);
    ena = 1'b1;
    cycles(1);
    pulseAck(); expectByte("E2", 3'd2, 8'h04);
    pulseAck(); expectByte("E3", 3'd3, 8'h03);
`ifdef CORDIC_SER_CHECKSUM_EN
    pulseAck(); expectByte("E4", 3'd4, 8'h04);
`endif
    pulseAck(); expectIdle("E end");

    // Back-to-back results with buffer back-pressure
    applyStimulus(16'h1234, 16'h5678);
    checkOutput("B2B ready2", 32'(res_ready), 32'd1);
    applyStimulus(16'hABCD, 16'hEF01);
    checkOutput("B2B full ready", 32'(res_ready), 32'd0);
    checkOutput("B2B busy", 32'(busy), 32'd1);
    res_valid = 1'b1; res_cos = 16'h1111; res_sin = 16'h2222;
    expectByte("R1 0", 3'd0, 8'h34);
    pulseAck(); expectByte("R1 1", 3'd1, 8'h12);
    pulseAck(); expectByte("R1 2", 3'd2, 8'h78);
    checkOutput("R3 held", 32'(res_ready), 32'd0);
`ifdef CORDIC_SER_CHECKSUM_EN
    pulseAck(); expectByte("R1 3", 3'd3, 8'h56);
    pulseAck(); expectByte("R1 4", 3'd4, 8'h08);
`else
    pulseAck(); expectByte("R1 3", 3'd3, 8'h56);
`endif
    gaps = 0;
    out_ack = 1'b1;
    for (int i = 0; i < SYNC + 2; i++) begin
      @(negedge clk);
      if (!byte_valid) gaps++;
    end
    out_ack = 1'b0;
    for (int i = 0; i < SYNC + 2; i++) begin
      @(negedge clk);
      if (!byte_valid) gaps++;
    end
    checkOutput("R2 no gap", 32'(gaps), 32'd0);
    res_valid = 1'b0;
    expectByte("R2 0", 3'd0, 8'hCD);
    checkOutput("R3 buffered busy", 32'(busy), 32'd1);
    checkOutput("R3 buffered ready", 32'(res_ready), 32'd0);
    pulseAck(); expectByte("R2 1", 3'd1, 8'hAB);
    pulseAck(); expectByte("R2 2", 3'd2, 8'h01);

    // Reset mid-frame at idx2
    rst_n = 1'b0;
    #1;
    checkOutput("midrst valid", 32'(byte_valid), 32'd0);
    checkOutput("midrst idx", 32'(byte_idx), 32'd0);
    checkOutput("midrst byte", 32'(byte_out), 32'h00);
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst ready", 32'(res_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    applyStimulus(16'h4DBA, 16'h2D41);
    expectByte("post rst 0", 3'd0, 8'hBA);
    pulseAck(); expectByte("post rst 1", 3'd1, 8'h4D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
